// File: rtl/core_sequencer.sv
// core_sequencer: multi-cycle fetch/decode/execute/memory/writeback control.
// Single-port memory handshake with per-transaction timeout and fault latch.
module core_sequencer #(
  parameter int                   WORD_SIZE   = 32,
  parameter logic [WORD_SIZE-1:0] RESET_PC    = '0,
  parameter int                   MEM_TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 step_mode,
  input  logic                 step,
  input  logic                 is_load,
  input  logic                 is_store,
  input  logic [1:0]           store_size,
  input  logic                 decode_error,
  input  logic [WORD_SIZE-1:0] eff_addr,
  input  logic [WORD_SIZE-1:0] next_pc,
  output logic                 mem_req,
  output logic [WORD_SIZE-1:0] mem_addr,
  output logic [1:0]           mem_we,
  input  logic                 mem_ready,
  input  logic [WORD_SIZE-1:0] mem_rdata,
  input  logic                 mem_err,
  output logic [WORD_SIZE-1:0] instr,
  output logic [WORD_SIZE-1:0] pc,
  output logic [WORD_SIZE-1:0] load_data,
  output logic                 reg_we,
  output logic [3:0]           state,
  output logic [1:0]           fault_code,
  output logic [31:0]          retired
);

  typedef enum logic [3:0] {
    S_START      = 4'd0,
    S_FETCH      = 4'd1,
    S_WAIT_FETCH = 4'd2,
    S_DECODE     = 4'd3,
    S_EXECUTE    = 4'd4,
    S_MEM_ACCESS = 4'd5,
    S_WAIT_MEM   = 4'd6,
    S_WRITEBACK  = 4'd7,
    S_FAULT      = 4'd15
  } state_t;

  localparam logic [1:0] F_DECODE  = 2'b01;
  localparam logic [1:0] F_MEM_ERR = 2'b10;
  localparam logic [1:0] F_TIMEOUT = 2'b11;

  // Last wait-count value still allowed to complete.
  localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     state_q;
  state_t     state_d;
  logic [7:0] wait_cnt;
  logic       st_q;
  logic [1:0] fault_d;

  logic go;
  logic in_wait;
  logic mem_done;
  logic tmo;
  logic req_fetch;
  logic req_mem;
  logic cap_instr;
  logic cap_load;
  logic retire;
  logic latch_op;
  logic drop_req;

  assign go       = !step_mode || step;
  assign in_wait  = (state_q == S_WAIT_FETCH) ||
                    (state_q == S_WAIT_MEM);
  assign mem_done = mem_req && mem_ready;
  assign tmo      = wait_cnt >= TMO_LAST;
  assign drop_req = in_wait && (state_d != state_q);

  assign state  = state_q;
  assign reg_we = (state_q == S_WRITEBACK) && !st_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_START;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    fault_d   = fault_code;
    req_fetch = 1'b0;
    req_mem   = 1'b0;
    cap_instr = 1'b0;
    cap_load  = 1'b0;
    retire    = 1'b0;
    latch_op  = 1'b0;
    unique case (state_q)
      S_START: begin
        state_d = S_FETCH;
      end
      S_FETCH: begin
        if (go) begin
          req_fetch = 1'b1;
          state_d   = S_WAIT_FETCH;
        end
      end
      S_WAIT_FETCH: begin
        if (mem_err) begin
          fault_d = F_MEM_ERR;
          state_d = S_FAULT;
        end else if (mem_done) begin
          cap_instr = 1'b1;
          state_d   = S_DECODE;
        end else if (tmo) begin
          fault_d = F_TIMEOUT;
          state_d = S_FAULT;
        end
      end
      S_DECODE: begin
        if (decode_error) begin
          fault_d = F_DECODE;
          state_d = S_FAULT;
        end else begin
          state_d = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        latch_op = 1'b1;
        if (is_load || is_store) begin
          state_d = S_MEM_ACCESS;
        end else begin
          state_d = S_WRITEBACK;
        end
      end
      S_MEM_ACCESS: begin
        req_mem = 1'b1;
        state_d = S_WAIT_MEM;
      end
      S_WAIT_MEM: begin
        if (mem_err) begin
          fault_d = F_MEM_ERR;
          state_d = S_FAULT;
        end else if (mem_done) begin
          cap_load = 1'b1;
          state_d  = S_WRITEBACK;
        end else if (tmo) begin
          fault_d = F_TIMEOUT;
          state_d = S_FAULT;
        end
      end
      S_WRITEBACK: begin
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_FAULT: begin
        state_d = S_FAULT;
      end
      default: begin
        state_d = S_FAULT;
      end
    endcase
  end

  // Bus request registers: held stable for the whole transaction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_req  <= 1'b0;
      mem_addr <= '0;
      mem_we   <= 2'b00;
      wait_cnt <= 8'd0;
    end else if (req_fetch) begin
      mem_req  <= 1'b1;
      mem_addr <= pc;
      mem_we   <= 2'b00;
      wait_cnt <= 8'd0;
    end else if (req_mem) begin
      mem_req  <= 1'b1;
      mem_addr <= eff_addr;
      mem_we   <= st_q ? store_size : 2'b00;
      wait_cnt <= 8'd0;
    end else if (drop_req) begin
      mem_req <= 1'b0;
      mem_we  <= 2'b00;
    end else if (in_wait) begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc         <= RESET_PC;
      instr      <= '0;
      load_data  <= '0;
      retired    <= 32'd0;
      fault_code <= 2'b00;
      st_q       <= 1'b0;
    end else begin
      fault_code <= fault_d;
      if (latch_op) begin
        st_q <= is_store;
      end
      if (cap_instr) begin
        instr <= mem_rdata;
      end
      if (cap_load) begin
        load_data <= mem_rdata;
      end
      if (retire) begin
        pc      <= next_pc;
        retired <= retired + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_core_sequencer.sv
// tb_core_sequencer: scoreboard bench for core_sequencer.
// A latency-programmable memory model answers every request.
module tb_core_sequencer;

  localparam int K_ALU = 0;
  localparam int K_LD  = 1;
  localparam int K_ST  = 2;

  logic        clk;
  logic        rst;
  logic        step_mode;
  logic        step;
  logic        is_load;
  logic        is_store;
  logic [1:0]  store_size;
  logic        decode_error;
  logic [31:0] eff_addr;
  logic [31:0] next_pc;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [1:0]  mem_we;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        mem_err;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] load_data;
  logic        reg_we;
  logic [3:0]  state;
  logic [1:0]  fault_code;
  logic [31:0] retired;

  core_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .step_mode    (step_mode),
    .step         (step),
    .is_load      (is_load),
    .is_store     (is_store),
    .store_size   (store_size),
    .decode_error (decode_error),
    .eff_addr     (eff_addr),
    .next_pc      (next_pc),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_we       (mem_we),
    .mem_ready    (mem_ready),
    .mem_rdata    (mem_rdata),
    .mem_err      (mem_err),
    .instr        (instr),
    .pc           (pc),
    .load_data    (load_data),
    .reg_we       (reg_we),
    .state        (state),
    .fault_code   (fault_code),
    .retired      (retired)
  );

  typedef struct {
    logic        we;
    logic [31:0] instr;
    logic        ld;
    logic [31:0] ldv;
    logic [31:0] pc;
    logic [31:0] ret;
  } exp_t;

  exp_t        sb[$];
  exp_t        pend;
  bit          pend_v;
  int          n_chk;
  int          n_pass;
  int          lat;
  bit          hang;
  bit          err_mode;
  logic [31:0] load_val;
  logic [31:0] pc_model;
  logic [31:0] ret_model;
  logic [1:0]  exp_mwe;
  logic [31:0] exp_maddr;
  int          req_cycles;
  bit          trace_on;
  logic [3:0]  trace[$];

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  function automatic logic [31:0] fw(input logic [31:0] a);
    return (a << 8) | 32'h0000_0013;
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory model: ready after `lat` wait cycles unless hung.
  initial begin
    int rcnt;
    rcnt      = 0;
    mem_ready = 1'b0;
    mem_err   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_req) begin
        rcnt++;
        mem_ready = !hang && (rcnt > lat);
        mem_err   = err_mode && (rcnt > lat);
        mem_rdata = (state == 4'd2) ? fw(mem_addr) : load_val;
      end else begin
        rcnt      = 0;
        mem_ready = 1'b0;
        mem_err   = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      if (trace_on) trace.push_back(state);
      if (mem_req) req_cycles++;
      if (pend_v) begin
        chk("wb_pc", pc, pend.pc);
        chk("wb_retired", retired, pend.ret);
        pend_v = 1'b0;
      end
      if (state == 4'd7) begin
        if (sb.size() == 0) begin
          chk("sb_unexpected_wb", 0, 1);
        end else begin
          pend = sb.pop_front();
          chk("reg_we", reg_we, pend.we);
          chk("instr", instr, pend.instr);
          if (pend.ld) chk("load_data", load_data, pend.ldv);
          pend_v = 1'b1;
        end
      end
      if (state == 4'd6 && mem_req) begin
        chk("mem_we_hold", mem_we, exp_mwe);
        chk("mem_addr_hold", mem_addr, exp_maddr);
      end
    end
  end

  task automatic setup(input int kind, input int lat_i,
                       input logic [31:0] ea, input logic [1:0] sz,
                       input logic [31:0] ldv, input bit dec_err,
                       input bit wb);
    exp_t e;
    is_load      = (kind == K_LD);
    is_store     = (kind == K_ST);
    store_size   = sz;
    eff_addr     = ea;
    next_pc      = pc_model + 32'd4;
    decode_error = dec_err;
    lat          = lat_i;
    load_val     = ldv;
    exp_mwe      = (kind == K_ST) ? sz : 2'b00;
    exp_maddr    = ea;
    if (wb) begin
      e.we    = (kind != K_ST);
      e.instr = fw(pc_model);
      e.ld    = (kind == K_LD);
      e.ldv   = ldv;
      e.pc    = pc_model + 32'd4;
      e.ret   = ret_model + 32'd1;
      sb.push_back(e);
      pc_model  = pc_model + 32'd4;
      ret_model = ret_model + 32'd1;
    end
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      #1;
      if (sb.size() == 0 && !pend_v) return;
    end
    chk(tag, 0, 1);
  endtask

  task automatic wait_state(input logic [3:0] s, input int lim,
                            input string tag);
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      #1;
      if (state == s) return;
    end
    chk(tag, state, s);
  endtask

  task automatic reset_on();
    rst       = 1'b0;
    sb.delete();
    pend_v    = 1'b0;
    pc_model  = 32'd0;
    ret_model = 32'd0;
    hang      = 1'b0;
    err_mode  = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int exp_tr[6];
    logic [3:0] tr[$];
    logic [31:0] r0;
    exp_tr = '{1, 2, 3, 4, 7, 1};
    n_chk = 0; n_pass = 0; pend_v = 0; trace_on = 0;
    req_cycles = 0;
    step_mode = 0; step = 0;
    is_load = 0; is_store = 0; store_size = 0;
    decode_error = 0; eff_addr = 0; next_pc = 0;
    lat = 0; hang = 0; err_mode = 0; load_val = 0;
    exp_mwe = 0; exp_maddr = 0;
    rst = 1'b0;
    reset_on();

    chk("rst_state", state, 0);
    chk("rst_pc", pc, 0);
    chk("rst_instr", instr, 0);
    chk("rst_load_data", load_data, 0);
    chk("rst_retired", retired, 0);
    chk("rst_fault", fault_code, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_reg_we", reg_we, 0);

    // ALU, ready one cycle after request, with state trace.
    setup(K_ALU, 0, 32'h0, 2'b00, 32'h0, 0, 1);
    trace_on = 1;
    rst = 1'b1;
    wait_done("alu_done");
    trace_on = 0;
    foreach (trace[i]) begin
      if (trace[i] != 0 &&
          (tr.size() == 0 || tr[tr.size()-1] != trace[i]))
        tr.push_back(trace[i]);
    end
    chk("trace_len", tr.size(), 6);
    for (int i = 0; i < 6; i++) chk("trace", tr[i], exp_tr[i]);

    setup(K_ST, 3, 32'h100, 2'b10, 32'h0, 0, 1);
    wait_done("store_done");

    setup(K_LD, 5, 32'h40, 2'b00, 32'hDEADBEEF, 0, 1);
    wait_done("load_done");

    // Ready on the very cycle the timeout would fire.
    setup(K_ALU, 14, 32'h0, 2'b00, 32'h0, 0, 1);
    wait_done("edge_done");

    req_cycles = 0;
    hang = 1;
    setup(K_ALU, 0, 32'h0, 2'b00, 32'h0, 0, 0);
    wait_state(4'd15, 60, "tmo_reach");
    repeat (5) @(negedge clk);
    #1;
    chk("tmo_state", state, 15);
    chk("tmo_code", fault_code, 3);
    chk("tmo_mem_req", mem_req, 0);
    chk("tmo_req_cycles", req_cycles, 15);
    chk("tmo_retired", retired, ret_model);
    chk("tmo_pc", pc, pc_model);

    reset_on();
    setup(K_ALU, 0, 32'h0, 2'b00, 32'h0, 1, 0);
    rst = 1'b1;
    wait_state(4'd15, 30, "dec_reach");
    repeat (3) @(negedge clk);
    #1;
    chk("dec_code", fault_code, 1);
    chk("dec_retired", retired, 0);
    chk("dec_reg_we", reg_we, 0);

    reset_on();
    err_mode = 1;
    setup(K_ALU, 0, 32'h0, 2'b00, 32'h0, 0, 0);
    rst = 1'b1;
    wait_state(4'd15, 30, "err_reach");
    #1;
    chk("err_code", fault_code, 2);
    chk("err_instr", instr, 0);

    reset_on();
    step_mode = 1;
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      r0 = ret_model;
      setup(K_ALU, 1, 32'h0, 2'b00, 32'h0, 0, 1);
      repeat (4) @(negedge clk);
      #1;
      chk("step_hold_state", state, 1);
      chk("step_hold_retired", retired, r0);
      step = 1;
      @(negedge clk);
      step = 0;
      wait_done("step_done");
    end
    repeat (6) @(negedge clk);
    #1;
    chk("step_retired", retired, 3);
    chk("step_idle_state", state, 1);

    setup(K_LD, 8, 32'h200, 2'b00, 32'h12345678, 0, 1);
    step_mode = 0;
    wait_state(4'd6, 30, "midrst_reach");
    rst = 1'b0;
    sb.delete();
    pend_v = 0;
    #1;
    chk("midrst_state", state, 0);
    chk("midrst_pc", pc, 0);
    chk("midrst_retired", retired, 0);
    chk("midrst_mem_req", mem_req, 0);
    chk("midrst_reg_we", reg_we, 0);
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
